// File: rtl/pong_if.sv
// Signal bundle between the pong game controller and the surrounding video/input logic.
interface pong_if;
  logic       refr_tick;
  logic [3:0] btn;
  logic       hit;
  logic       miss;
  logic       miss_side;
  logic       graph_still;
  logic [1:0] state_o;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [7:0] rally;
  logic       winner;

  modport slave (
    input  refr_tick, btn, hit, miss, miss_side,
    output graph_still, state_o, score_l, score_r, rally, winner
  );

  modport master (
    output refr_tick, btn, hit, miss, miss_side,
    input  graph_still, state_o, score_l, score_r, rally, winner
  );
endinterface

// File: rtl/pong_ctrl.sv
// Pong game sequencer: serve pauses, scoring, BCD rally count and game-over hold.
// Optional macro PONG_CTRL_SERVE_BTN_EN: a serve additionally waits for a button press.
//
// state   | meaning
// NEWGAME | idle, previous scores on display, waiting for start
// PLAY    | ball in play, counting hits and watching for a miss
// NEWBALL | frame-timed pause before the next serve
// OVER    | frame-timed game-over hold, winner valid
module pong_ctrl #(
  parameter int WIN_SCORE      = 5,
  parameter int NEWBALL_FRAMES = 120,
  parameter int OVER_FRAMES    = 180
) (
  input  logic   clk,
  input  logic   reset,
  pong_if.slave  bus
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic [7:0] rally_q, rally_d;
  logic       winner_q, winner_d;
  logic       hit_q;
  logic       graph_still_q;

  logic       start;
  logic       hit_rise;
  logic [3:0] pts_new;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign start    = |bus.btn;
  assign hit_rise = bus.hit & ~hit_q;
  assign pts_new  = bus.miss_side ? (score_l_q + 4'd1) : (score_r_q + 4'd1);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    rally_d   = rally_q;
    winner_d  = winner_q;

    if (bus.refr_tick && (timer_q != 8'd0))
      timer_d = timer_q - 8'd1;

    case (state_q)
      NEWGAME: begin
        if (start) begin
          state_d   = PLAY;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          rally_d   = 8'h00;
          winner_d  = 1'b0;
        end
      end
      PLAY: begin
        // a miss wins over a simultaneous hit edge
        if (bus.miss) begin
          rally_d = 8'h00;
          if (bus.miss_side)
            score_l_d = pts_new;
          else
            score_r_d = pts_new;
          if (pts_new == 4'(WIN_SCORE)) begin
            state_d  = OVER;
            winner_d = ~bus.miss_side;
            timer_d  = 8'(OVER_FRAMES);
          end else begin
            state_d = NEWBALL;
            timer_d = 8'(NEWBALL_FRAMES);
          end
        end else if (hit_rise) begin
          rally_d = bcd_inc(rally_q);
        end
      end
      NEWBALL: begin
`ifdef PONG_CTRL_SERVE_BTN_EN
        if ((timer_q == 8'd0) && start)
          state_d = PLAY;
`else
        if (timer_q == 8'd0)
          state_d = PLAY;
`endif
      end
      OVER: begin
        if (timer_q == 8'd0)
          state_d = NEWGAME;
      end
      default: state_d = NEWGAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= NEWGAME;
      timer_q       <= 8'd0;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      rally_q       <= 8'h00;
      winner_q      <= 1'b0;
      hit_q         <= 1'b0;
      graph_still_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      rally_q       <= rally_d;
      winner_q      <= winner_d;
      hit_q         <= bus.hit;
      graph_still_q <= (state_d != PLAY);
    end
  end

  assign bus.graph_still = graph_still_q;
  assign bus.state_o     = state_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.rally       = rally_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_ctrl.sv
// Directed bench for pong_ctrl with hand-computed expectations.
module tb_pong_ctrl;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  pong_if bus ();

  pong_ctrl #(.WIN_SCORE(5), .NEWBALL_FRAMES(120), .OVER_FRAMES(180)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.refr_tick = 1'b1;
      step();
      bus.refr_tick = 1'b0;
      step();
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      bus.hit = 1'b1;
      step(); step(); step();
      bus.hit = 1'b0;
      step();
    end
  endtask

  task automatic point(input logic side);
    bus.miss_side = side;
    bus.miss      = 1'b1;
    step();
    bus.miss      = 1'b0;
  endtask

  // NEWBALL pause of 120 frames; the exit lands one cycle after the last tick
  task automatic serve();
    ticks(119);
    check("nb_hold_119", 32'(bus.state_o), 32'd2);
    bus.refr_tick = 1'b1;
    step();
    bus.refr_tick = 1'b0;
    check("nb_timer0", 32'(bus.state_o), 32'd2);
    step();
`ifdef PONG_CTRL_SERVE_BTN_EN
    check("nb_wait_btn", 32'(bus.state_o), 32'd2);
    ticks(80);
    check("nb_wait_200", 32'(bus.state_o), 32'd2);
    bus.btn = 4'b1000;
    step();
    bus.btn = 4'b0000;
`endif
    check("nb_to_play", 32'(bus.state_o), 32'd1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    bus.refr_tick = 1'b0;
    bus.btn       = 4'b0000;
    bus.hit       = 1'b0;
    bus.miss      = 1'b0;
    bus.miss_side = 1'b0;
    reset = 1'b1;
    #12;
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_still", 32'(bus.graph_still), 32'd1);
    check("rst_scores", {24'd0, bus.score_l, bus.score_r}, 32'd0);
    check("rst_rally", 32'(bus.rally), 32'h00);
    check("rst_winner", 32'(bus.winner), 32'd0);
    step();
    reset = 1'b0;
    step(); step(); step();
    check("idle_wait", 32'(bus.state_o), 32'd0);

    bus.btn = 4'b0001;
    step();
    bus.btn = 4'b0000;
    check("start_state", 32'(bus.state_o), 32'd1);
    check("start_still", 32'(bus.graph_still), 32'd0);
    check("start_scores", {24'd0, bus.score_l, bus.score_r}, 32'd0);

    hits(12);
    check("rally_12", 32'(bus.rally), 32'h12);
    hits(88);
    check("rally_sat", 32'(bus.rally), 32'h99);
    hits(3);
    check("rally_sat2", 32'(bus.rally), 32'h99);

    // miss coincides with a frame tick: fresh timer load must not be decremented
    bus.refr_tick = 1'b1;
    point(1'b0);
    bus.refr_tick = 1'b0;
    check("miss_r_score", 32'(bus.score_r), 32'd1);
    check("miss_r_rally", 32'(bus.rally), 32'h00);
    check("miss_r_state", 32'(bus.state_o), 32'd2);
    check("miss_r_still", 32'(bus.graph_still), 32'd1);
    point(1'b1);
    step();
    check("nb_ignore_miss", 32'(bus.score_l), 32'd0);
    bus.btn = 4'b0010;
    step();
    bus.btn = 4'b0000;
    check("nb_ignore_btn", 32'(bus.state_o), 32'd2);
    serve();

    hits(1);
    check("rally_one", 32'(bus.rally), 32'h01);
    bus.hit = 1'b1;
    point(1'b1);
    bus.hit = 1'b0;
    check("both_rally", 32'(bus.rally), 32'h00);
    check("both_score_l", 32'(bus.score_l), 32'd1);
    check("both_state", 32'(bus.state_o), 32'd2);
    serve();
    check("both_rally_kept", 32'(bus.rally), 32'h00);

    for (int i = 0; i < 3; i++) begin
      point(1'b1);
      serve();
    end
    check("score_l_4", 32'(bus.score_l), 32'd4);
    point(1'b1);
    check("over_score_l", 32'(bus.score_l), 32'd5);
    check("over_score_r", 32'(bus.score_r), 32'd1);
    check("over_state", 32'(bus.state_o), 32'd3);
    check("over_winner_l", 32'(bus.winner), 32'd0);
    ticks(179);
    check("over_hold_179", 32'(bus.state_o), 32'd3);
    ticks(1);
    check("over_to_newgame", 32'(bus.state_o), 32'd0);
    check("newgame_keep_l", 32'(bus.score_l), 32'd5);
    check("newgame_keep_w", 32'(bus.winner), 32'd0);
    check("newgame_still", 32'(bus.graph_still), 32'd1);

    bus.btn = 4'b1000;
    step();
    bus.btn = 4'b0000;
    check("restart_state", 32'(bus.state_o), 32'd1);
    check("restart_scores", {24'd0, bus.score_l, bus.score_r}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      point(1'b0);
      serve();
    end
    point(1'b0);
    check("over_r_state", 32'(bus.state_o), 32'd3);
    check("over_r_winner", 32'(bus.winner), 32'd1);
    check("over_r_score", 32'(bus.score_r), 32'd5);

    ticks(50);
    #3;
    reset = 1'b1;
    #1;
    check("abort_state", 32'(bus.state_o), 32'd0);
    check("abort_scores", {24'd0, bus.score_l, bus.score_r}, 32'd0);
    check("abort_winner", 32'(bus.winner), 32'd0);
    check("abort_still", 32'(bus.graph_still), 32'd1);
    step();
    reset = 1'b0;
    step(); step();
    check("abort_wait", 32'(bus.state_o), 32'd0);

    // reset in the middle of a serve pause
    bus.btn = 4'b0100;
    step();
    bus.btn = 4'b0000;
    point(1'b1);
    ticks(30);
    check("mid_nb_state", 32'(bus.state_o), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_nb_reset", 32'(bus.state_o), 32'd0);
    check("mid_nb_score", 32'(bus.score_l), 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
